wave_seq_ctrl: RTL and testbench
================================

WAVE_SEQ_CTRL -- requirements
Module: wave_seq_ctrl

Interface
REQ-001 SHALL have parameter DA_W, default 10, DA output sample width.
REQ-002 SHALL have parameter FRAC_W, default 6, accumulator fraction bits.
REQ-003 SHALL have parameter STEP_W, default 14, signed two's-complement step width.
REQ-004 SHALL have parameter CNT_W, default 8, segment sample-count width; WORD_W = DA_W+STEP_W+CNT_W (default 32).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rstn  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port word_in  in  WORD_W  segment word: [CNT_W-1:0] samples, next STEP_W bits step, top DA_W bits start.
REQ-008 SHALL have ports word_valid  in  1 and word_ready  out  1, forming the segment-word handshake.
REQ-009 SHALL have port data_req  in  1  request for one DA sample.
REQ-010 SHALL have ports da_data  out  DA_W and da_valid  out  1, carrying the sample and its strobe.
REQ-011 SHALL have ports vol_max  in  DA_W and slope_max  in  STEP_W-1, the output ceiling and the magnitude limit on step.
REQ-012 SHALL have ports abort  in  1  synchronous flush and err_clr  in  1  sticky-flag clear.
REQ-013 SHALL have ports seg_done  out  1, busy  out  1, vol_err  out  1, slope_err  out  1 and underrun_err  out  1.

Function
REQ-014 SHALL hold two word registers: active segment and one-deep prefetch; word_ready = prefetch empty; transfer on word_valid && word_ready.
REQ-015 SHALL use states IDLE (no active segment) and RUN (active segment loaded); busy = (state==RUN).
REQ-016 SHALL move a word to active in the same cycle as its acceptance when active is empty, or in the cycle its predecessor finishes when the word is in prefetch.
REQ-017 SHALL serve a segment with samples=N>=1 using exactly N data_req pulses: pulse 1 outputs start, each later pulse outputs previous value plus step.
REQ-018 SHALL retire a segment with samples=0 in the cycle after it becomes active, with no sample issued and a seg_done pulse.
REQ-019 SHALL assert seg_done for one cycle on the cycle after the N-th sample of a segment is issued.
REQ-020 SHALL, when the N-th data_req of a segment arrives and prefetch holds a word, serve the next data_req from the new segment start with no gap cycle.
REQ-021 SHALL register da_data and assert da_valid exactly one cycle after each served data_req; da_data SHALL hold its value at all other times.
REQ-022 SHALL set underrun_err and leave da_valid low on a data_req received in IDLE.
REQ-023 SHALL keep the accumulator at DA_W+FRAC_W+2 signed bits, load it with {start, FRAC_W zeros}, and add the sign-extended effective step on each served data_req.
REQ-024 SHALL saturate the accumulator to the range [0, 2^(DA_W+FRAC_W)-1]; no wrap-around.
REQ-025 SHALL take the effective step as +/-slope_max (sign of step) when |step| > slope_max, else step, with |step| computed in STEP_W+1 bits so that -2^(STEP_W-1) is handled; slope_err is set on a clamp.
REQ-026 SHALL drive da_data = min(acc[DA_W+FRAC_W-1:FRAC_W], vol_max) combinationally before the output register, with vol_err set on a clamp.
REQ-027 SHALL keep the error flags sticky until err_clr; a set and an err_clr in the same cycle leave the flag set.
REQ-028 SHALL, on abort, empty both word registers, enter IDLE, suppress seg_done and da_valid that cycle, hold da_data, and leave the error flags unchanged; abort has priority over data_req and word acceptance.

Reset
REQ-029 SHALL, while rstn is low, drive state IDLE, both word registers empty, accumulator 0, da_data 0, and all strobes and error flags 0; word_ready SHALL be 1 from the first cycle after release.

Structure
REQ-030 SHALL place the parameter defaults, the word field offset/width constants and the state encoding in package wave_seq_pkg.
REQ-031 SHALL implement the slope and volume clamps in sub-module wave_seq_limiter, combinational, which outputs the effective step, the clamped sample and the two clamp flags.

Verification
REQ-032 SHALL cover: start=100, step=+64, samples=4, 4 data_req -> da_data 100,101,102,103; seg_done once.
REQ-033 SHALL cover: two words queued back-to-back (100/+64/2, then 500/-128/2) with data_req every cycle -> 100,101,500,498, no gap, two seg_done pulses.
REQ-034 SHALL cover: step=+8000, slope_max=640 -> increments of 10 LSB and slope_err=1; err_clr asserted together with a new clamp -> slope_err stays 1.
REQ-035 SHALL cover: start=1000, step=+640, vol_max=1005, 3 samples -> 1000,1005,1005 and vol_err=1; start=5, step=-640 -> 5,0,0 (saturated).
REQ-036 SHALL cover: samples=0 word -> seg_done with no da_valid; data_req in IDLE -> underrun_err=1.
REQ-037 SHALL cover: abort mid-segment with prefetch full -> busy=0, word_ready=1, da_data held; rstn pulsed mid-segment -> all outputs 0.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// -----------------------------------------------------------------------------
// wave_seq_pkg
// Shared definitions for the waveform sequencer slice.
//   - default widths for the DA sample, accumulator fraction, signed step and
//     segment sample count
//   - segment-word field offsets, as functions of the field widths so that a
//     re-parameterised instance stays consistent
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package wave_seq_pkg;

  localparam int DA_W_DEF   = 10;
  localparam int FRAC_W_DEF = 6;
  localparam int STEP_W_DEF = 14;
  localparam int CNT_W_DEF  = 8;

  // Segment word layout, LSB first: samples | step | start
  localparam int CNT_LSB = 0;

  function automatic int step_lsb(input int cnt_w);
    return CNT_LSB + cnt_w;
  endfunction

  function automatic int start_lsb(input int cnt_w, input int step_w);
    return CNT_LSB + cnt_w + step_w;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/wave_seq_limiter.sv
// -----------------------------------------------------------------------------
// wave_seq_limiter
// Purely combinational clamp stage.
//   step       in  signed step of the active segment
//   slope_max  in  magnitude limit for the step
//   level      in  integer part of the accumulator
//   vol_max    in  output ceiling
//   eff_step   out step after the slope clamp (sign preserved)
//   sample     out level after the volume clamp
//   slope_clip out step was clamped
//   vol_clip   out sample was clamped
// -----------------------------------------------------------------------------
module wave_seq_limiter
  import wave_seq_pkg::*;
#(
  parameter int DA_W   = DA_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic [STEP_W-1:0] step,
  input  logic [STEP_W-2:0] slope_max,
  input  logic [DA_W-1:0]   level,
  input  logic [DA_W-1:0]   vol_max,
  output logic [STEP_W-1:0] eff_step,
  output logic [DA_W-1:0]   sample,
  output logic              slope_clip,
  output logic              vol_clip
);

  logic              step_neg;
  logic [STEP_W:0]   step_mag;
  logic [STEP_W:0]   limit_ext;

  // The magnitude is one bit wider than the step so that the most negative
  // step value still yields its true positive magnitude.
  always_comb begin
    step_neg   = step[STEP_W-1];
    step_mag   = step_neg ? (~{1'b1, step} + 1'b1) : {1'b0, step};
    limit_ext  = {2'b00, slope_max};
    slope_clip = (step_mag > limit_ext);
    if (slope_clip) begin
      eff_step = step_neg ? (~{1'b0, slope_max} + 1'b1) : {1'b0, slope_max};
    end else begin
      eff_step = step;
    end
    vol_clip = (level > vol_max);
    sample   = vol_clip ? vol_max : level;
  end

endmodule

// File: rtl/wave_seq_ctrl.sv
// -----------------------------------------------------------------------------
// wave_seq_ctrl
// Segment-based DA waveform sequencer with a one-deep word prefetch.
//   clk, rstn                 clock, asynchronous active-low reset
//   word_in/valid/ready       segment word handshake (samples|step|start)
//   data_req                  request for one DA sample
//   da_data, da_valid         registered sample and its strobe
//   vol_max, slope_max        output ceiling, step magnitude limit
//   abort, err_clr            synchronous flush, sticky-flag clear
//   seg_done, busy            segment retired pulse, active segment present
//   vol_err, slope_err,
//   underrun_err              sticky clamp / underrun flags
// -----------------------------------------------------------------------------
module wave_seq_ctrl
  import wave_seq_pkg::*;
#(
  parameter  int DA_W   = DA_W_DEF,
  parameter  int FRAC_W = FRAC_W_DEF,
  parameter  int STEP_W = STEP_W_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int WORD_W = DA_W + STEP_W + CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              data_req,
  output logic [DA_W-1:0]   da_data,
  output logic              da_valid,
  input  logic [DA_W-1:0]   vol_max,
  input  logic [STEP_W-2:0] slope_max,
  input  logic              abort,
  input  logic              err_clr,
  output logic              seg_done,
  output logic              busy,
  output logic              vol_err,
  output logic              slope_err,
  output logic              underrun_err
);

  localparam int ACC_W     = DA_W + FRAC_W + 2;
  localparam int STEP_LSB  = step_lsb(CNT_W);
  localparam int START_LSB = start_lsb(CNT_W, STEP_W);

  seq_state_e        state_q, state_d;
  logic              pf_valid_q, pf_valid_d;
  logic [WORD_W-1:0] pf_word_q, pf_word_d;
  logic [STEP_W-1:0] act_step_q, act_step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DA_W-1:0]   da_data_q, da_data_d;
  logic              da_valid_q, da_valid_d;
  logic              seg_done_q, seg_done_d;
  logic              vol_err_q, vol_err_d;
  logic              slope_err_q, slope_err_d;
  logic              underrun_err_q, underrun_err_d;
  logic              ready_en_q, ready_en_d;

  logic              run, accept, serve, finish, act_free, underrun;
  logic [STEP_W-1:0] lim_step;
  logic [DA_W-1:0]   lim_sample;
  logic              lim_slope_clip, lim_vol_clip;
  logic [ACC_W-1:0]  step_sx, acc_sum, acc_sat;
  logic [WORD_W-1:0] load_word;

  wave_seq_limiter #(
    .DA_W   (DA_W),
    .STEP_W (STEP_W)
  ) u_limiter (
    .step       (act_step_q),
    .slope_max  (slope_max),
    .level      (acc_q[DA_W+FRAC_W-1:FRAC_W]),
    .vol_max    (vol_max),
    .eff_step   (lim_step),
    .sample     (lim_sample),
    .slope_clip (lim_slope_clip),
    .vol_clip   (lim_vol_clip)
  );

  // ready_en keeps word_ready low during reset and raises it on the first edge after release.
  assign word_ready = ready_en_q && !pf_valid_q;
  assign run        = (state_q == ST_RUN);
  assign accept     = word_valid && word_ready && !abort;
  assign serve      = run && data_req && (cnt_q != '0) && !abort;
  // A zero-sample segment retires in its first active cycle; otherwise on its last served request.
  assign finish     = run && !abort && ((cnt_q == '0) || (serve && (cnt_q == CNT_W'(1))));
  assign act_free   = !run || finish;
  assign underrun   = !run && data_req && !abort;

  // Two's-complement add; the top two bits flag negative result or overflow.
  always_comb begin
    step_sx = {{(ACC_W-STEP_W){lim_step[STEP_W-1]}}, lim_step};
    acc_sum = acc_q + step_sx;
    if (acc_sum[ACC_W-1]) begin
      acc_sat = '0;
    end else if (acc_sum[ACC_W-2]) begin
      acc_sat = {2'b00, {(DA_W+FRAC_W){1'b1}}};
    end else begin
      acc_sat = acc_sum;
    end
  end

  // Next-state: serve first, then word movement, which overrides the
  // accumulator when a new segment takes over; abort overrides everything.
  always_comb begin
    state_d        = state_q;
    pf_valid_d     = pf_valid_q;
    pf_word_d      = pf_word_q;
    act_step_d     = act_step_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    da_data_d      = da_data_q;
    da_valid_d     = serve;
    seg_done_d     = finish;
    ready_en_d     = 1'b1;
    load_word      = '0;
    vol_err_d      = (vol_err_q      && !err_clr) || (serve && lim_vol_clip);
    slope_err_d    = (slope_err_q    && !err_clr) || (serve && lim_slope_clip);
    underrun_err_d = (underrun_err_q && !err_clr) || underrun;

    if (serve) begin
      da_data_d = lim_sample;
      acc_d     = acc_sat;
      cnt_d     = cnt_q - CNT_W'(1);
    end

    if (abort) begin
      state_d    = ST_IDLE;
      pf_valid_d = 1'b0;
      da_valid_d = 1'b0;
      seg_done_d = 1'b0;
    end else if (act_free && (pf_valid_q || accept)) begin
      load_word  = pf_valid_q ? pf_word_q : word_in;
      state_d    = ST_RUN;
      pf_valid_d = 1'b0;
      act_step_d = load_word[STEP_LSB +: STEP_W];
      cnt_d      = load_word[CNT_LSB +: CNT_W];
      acc_d      = {2'b00, load_word[START_LSB +: DA_W], {FRAC_W{1'b0}}};
    end else if (act_free) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      pf_word_d  = word_in;
      pf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      pf_valid_q     <= 1'b0;
      pf_word_q      <= '0;
      act_step_q     <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      da_data_q      <= '0;
      da_valid_q     <= 1'b0;
      seg_done_q     <= 1'b0;
      vol_err_q      <= 1'b0;
      slope_err_q    <= 1'b0;
      underrun_err_q <= 1'b0;
      ready_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pf_valid_q     <= pf_valid_d;
      pf_word_q      <= pf_word_d;
      act_step_q     <= act_step_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      da_data_q      <= da_data_d;
      da_valid_q     <= da_valid_d;
      seg_done_q     <= seg_done_d;
      vol_err_q      <= vol_err_d;
      slope_err_q    <= slope_err_d;
      underrun_err_q <= underrun_err_d;
      ready_en_q     <= ready_en_d;
    end
  end

  assign da_data      = da_data_q;
  assign da_valid     = da_valid_q;
  assign seg_done     = seg_done_q;
  assign busy         = run;
  assign vol_err      = vol_err_q;
  assign slope_err    = slope_err_q;
  assign underrun_err = underrun_err_q;

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wave_seq_ctrl
// Directed bench for wave_seq_ctrl at default parameters. Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point, so every
// check sees the registers updated by the edge just taken.
// -----------------------------------------------------------------------------
module tb_wave_seq_ctrl;

  logic        clk;
  logic        rstn;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        data_req;
  logic [9:0]  da_data;
  logic        da_valid;
  logic [9:0]  vol_max;
  logic [12:0] slope_max;
  logic        abort;
  logic        err_clr;
  logic        seg_done;
  logic        busy;
  logic        vol_err;
  logic        slope_err;
  logic        underrun_err;

  int checks = 0;
  int errors = 0;

  wave_seq_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .data_req     (data_req),
    .da_data      (da_data),
    .da_valid     (da_valid),
    .vol_max      (vol_max),
    .slope_max    (slope_max),
    .abort        (abort),
    .err_clr      (err_clr),
    .seg_done     (seg_done),
    .busy         (busy),
    .vol_err      (vol_err),
    .slope_err    (slope_err),
    .underrun_err (underrun_err)
  );

  // 100 MHz free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if something stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Builds a segment word {start, step, samples}
  function automatic logic [31:0] mk(input int start, input int step, input int n);
    logic [31:0] s, t, c;
    s = start;
    t = step;
    c = n;
    return {s[9:0], t[13:0], c[7:0]};
  endfunction

  // Drives one cycle of inputs and advances to just after the next edge
  task automatic applyStimulus(input logic wv, input logic [31:0] w, input logic dr,
                               input logic ab, input logic ec);
    word_valid = wv;
    word_in    = w;
    data_req   = dr;
    abort      = ab;
    err_clr    = ec;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Checks one served sample beat plus the seg_done strobe alongside it
  task automatic checkBeat(input string tag, input int data, input logic done);
    checkOutput({tag, ".valid"}, 32'(da_valid), 32'd1);
    checkOutput({tag, ".data"}, 32'(da_data), 32'(data));
    checkOutput({tag, ".done"}, 32'(seg_done), 32'(done));
  endtask

  // Directed sequence
  initial begin
    rstn       = 1'b1;
    word_in    = '0;
    word_valid = 1'b0;
    data_req   = 1'b0;
    abort      = 1'b0;
    err_clr    = 1'b0;
    vol_max    = 10'd1023;
    slope_max  = 13'd8191;
    #1 rstn = 1'b0;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("rst.da_data", 32'(da_data), 0);
    checkOutput("rst.da_valid", 32'(da_valid), 0);
    checkOutput("rst.busy", 32'(busy), 0);
    checkOutput("rst.word_ready", 32'(word_ready), 0);
    checkOutput("rst.flags", 32'({vol_err, slope_err, underrun_err, seg_done}), 0);
    rstn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rel.word_ready", 32'(word_ready), 1);
    checkOutput("rel.busy", 32'(busy), 0);

    // Ramp: 100/+64/4 -> 100..103
    applyStimulus(1, mk(100, 64, 4), 0, 0, 0);
    checkOutput("a.busy", 32'(busy), 1);
    checkOutput("a.ready", 32'(word_ready), 1);
    checkOutput("a.nodata", 32'(da_valid), 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("a1", 100, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("a2", 101, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("a3", 102, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("a4", 103, 1);
    checkOutput("a.idle", 32'(busy), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("a.hold", 32'(da_data), 103);
    checkOutput("a.novalid", 32'(da_valid), 0);
    checkOutput("a.donelow", 32'(seg_done), 0);

    // Back-to-back: 100/+64/2 then 500/-128/2, data_req every cycle
    applyStimulus(1, mk(100, 64, 2), 0, 0, 0);
    applyStimulus(1, mk(500, -128, 2), 1, 0, 0);
    checkBeat("b1", 100, 0);
    checkOutput("b.pf_full", 32'(word_ready), 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("b2", 101, 1);
    checkOutput("b.busy_swap", 32'(busy), 1);
    checkOutput("b.pf_empty", 32'(word_ready), 1);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("b3", 500, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("b4", 498, 1);
    checkOutput("b.idle", 32'(busy), 0);

    // Slope clamp: +8000 limited to 640 (10 LSB per sample)
    slope_max = 13'd640;
    applyStimulus(1, mk(0, 8000, 3), 0, 0, 0);
    checkOutput("c.slope_pre", 32'(slope_err), 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("c1", 0, 0);
    checkOutput("c.slope_set", 32'(slope_err), 1);
    applyStimulus(0, 0, 1, 0, 1); checkBeat("c2", 10, 0);
    checkOutput("c.slope_clr_set", 32'(slope_err), 1);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("c3", 20, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("c.slope_clr", 32'(slope_err), 0);

    // Volume clamp: 1000/+640 with ceiling 1005
    vol_max = 10'd1005;
    applyStimulus(1, mk(1000, 640, 3), 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("d1", 1000, 0);
    checkOutput("d.vol_pre", 32'(vol_err), 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("d2", 1005, 0);
    checkOutput("d.vol_set", 32'(vol_err), 1);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("d3", 1005, 1);
    checkOutput("d.no_slope", 32'(slope_err), 0);

    // Floor saturation: 5/-640 -> 5,0,0
    vol_max = 10'd1023;
    applyStimulus(1, mk(5, -640, 3), 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("e1", 5, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("e2", 0, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("e3", 0, 1);

    // Zero-sample segment, then underrun in IDLE
    applyStimulus(1, mk(7, 0, 0), 0, 0, 0);
    checkOutput("z.busy", 32'(busy), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("z.done", 32'(seg_done), 1);
    checkOutput("z.novalid", 32'(da_valid), 0);
    checkOutput("z.idle", 32'(busy), 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("u.flag", 32'(underrun_err), 1);
    checkOutput("u.novalid", 32'(da_valid), 0);
    checkOutput("u.hold", 32'(da_data), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("u.clr", 32'({vol_err, underrun_err}), 0);

    // Abort mid-segment with the prefetch full
    applyStimulus(1, mk(200, 64, 5), 0, 0, 0);
    applyStimulus(1, mk(300, 0, 2), 1, 0, 0); checkBeat("f1", 200, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("f2", 201, 0);
    checkOutput("f.pf_full", 32'(word_ready), 0);
    applyStimulus(1, mk(900, 0, 1), 1, 1, 0);
    checkOutput("f.busy", 32'(busy), 0);
    checkOutput("f.ready", 32'(word_ready), 1);
    checkOutput("f.novalid", 32'(da_valid), 0);
    checkOutput("f.nodone", 32'(seg_done), 0);
    checkOutput("f.hold", 32'(da_data), 201);
    checkOutput("f.no_underrun", 32'(underrun_err), 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("f.stay_idle", 32'(busy), 0);
    checkOutput("f.underrun", 32'(underrun_err), 1);

    // Reset pulse mid-segment
    applyStimulus(1, mk(400, 64, 5), 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("g1", 400, 0);
    applyStimulus(0, 0, 1, 0, 0); checkBeat("g2", 401, 0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("g.da_data", 32'(da_data), 0);
    checkOutput("g.da_valid", 32'(da_valid), 0);
    checkOutput("g.busy", 32'(busy), 0);
    checkOutput("g.word_ready", 32'(word_ready), 0);
    checkOutput("g.flags", 32'({vol_err, slope_err, underrun_err, seg_done}), 0);
    data_req = 1'b0;
    #1 rstn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("g.rel_ready", 32'(word_ready), 1);
    checkOutput("g.rel_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
